// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, execute redirect and the IF/ID handshake to decode.
// The master modport is the fetch stage's view, and the slave modport is the environment's view.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures combinational imem words into an IF/ID register,
// honours execute redirects with flush, and parks in HALT on an all-zero (unprogrammed) word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    bus,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_nxt_s;
    logic [31:0]      pc_plus4_s;
    logic [31:0]      redirect_tgt_s;
    logic             advance_s;
    logic             zero_word_s;
    logic             capture_s;
    logic             out_valid_nxt_s;
    logic             handshake_s;
    logic             out_valid_r;
    logic [31:0]      out_instr_r;
    logic [31:0]      out_pc_r;
    logic [31:0]      out_pc_plus4_r;
    logic             halted_r;
    logic             misalign_err_r;
    logic [CNT_W-1:0] instr_count_r;

    assign pc_plus4_s     = pc_r + 32'd4;
    assign redirect_tgt_s = {bus.redirect_pc[31:2], 2'b00};
    assign advance_s      = !out_valid_r || bus.out_ready;
    assign zero_word_s    = (bus.imem_data == 32'h0000_0000);
    assign handshake_s    = out_valid_r && bus.out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a redirect overrides everything, including a zero word or a stall.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.redirect_valid) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_BOOT: state_nxt_s = ST_RUN;
                ST_RUN: begin
                    if (advance_s && zero_word_s) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
                default: state_nxt_s = ST_BOOT;
            endcase
        end
    end

    // Output/datapath decode: next PC, IF/ID capture enable and next out_valid.
    always_comb begin
        pc_nxt_s        = pc_r;
        capture_s       = 1'b0;
        out_valid_nxt_s = out_valid_r;
        if (bus.redirect_valid) begin
            pc_nxt_s        = redirect_tgt_s;
            out_valid_nxt_s = 1'b0;
        end else if ((state_r == ST_RUN) && advance_s) begin
            if (!zero_word_s) begin
                pc_nxt_s        = pc_plus4_s;
                capture_s       = 1'b1;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            pc_nxt_s        = pc_r;
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Program counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    // IF/ID register; a flush only drops out_valid, the payload may go stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r    <= 1'b0;
            out_instr_r    <= 32'h0000_0000;
            out_pc_r       <= 32'h0000_0000;
            out_pc_plus4_r <= 32'h0000_0000;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            if (capture_s) begin
                out_instr_r    <= bus.imem_data;
                out_pc_r       <= pc_r;
                out_pc_plus4_r <= pc_plus4_s;
            end
        end
    end

    // Status flags: halted tracks the HALT state, misalign pulses for one cycle per bad redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_r       <= 1'b0;
            misalign_err_r <= 1'b0;
        end else begin
            halted_r       <= (state_nxt_s == ST_HALT);
            misalign_err_r <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    // Completed-handshake counter; a handshake on a redirect edge still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_r <= {CNT_W{1'b0}};
        end else if (handshake_s) begin
            instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.imem_addr    = pc_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_instr    = out_instr_r;
    assign bus.out_pc       = out_pc_r;
    assign bus.out_pc_plus4 = out_pc_plus4_r;
    assign halted           = halted_r;
    assign misalign_err     = misalign_err_r;
    assign instr_count      = instr_count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected IF/ID handshakes plus
// point checks on PC, status flags and the instruction counter.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        halted;
    logic        misalign_err;
    logic [31:0] instr_count;

    int total;
    int bad;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];

    fetch_stage_if bus_if ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if.master),
        .halted       (halted),
        .misalign_err (misalign_err),
        .instr_count  (instr_count)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_read = 32'h0050_8413;
            32'h0000_0004: mem_read = 32'h0041_0503;
            32'h0000_0008: mem_read = 32'h0091_2223;
            32'h0000_0010: mem_read = 32'h0020_8433;
            32'hFFFF_FFFC: mem_read = 32'h0010_0093;
            default:       mem_read = 32'h0000_0000;
        endcase
    endfunction

    assign bus_if.imem_data = mem_read(bus_if.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Called just before an edge where out_valid && out_ready: pop and compare the accepted word.
    task automatic sb_pop_check();
        exp_t e;
        total++;
        assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL sb_underflow: observed=handshake pc=%h expected=no_handshake", bus_if.out_pc);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_instr", bus_if.out_instr, e.instr);
            chk("sb_pc", bus_if.out_pc, e.pc);
            chk("sb_pc_plus4", bus_if.out_pc_plus4, e.pc + 32'd4);
        end
    endtask

    task automatic tick();
        if (bus_if.out_valid && bus_if.out_ready) sb_pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus_if.out_ready      = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_addr", bus_if.imem_addr, 32'h0000_0000);
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_out_instr", bus_if.out_instr, 32'h0000_0000);
        chk("rst_out_pc", bus_if.out_pc, 32'h0000_0000);
        chk("rst_out_pc_plus4", bus_if.out_pc_plus4, 32'h0000_0000);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_count", instr_count, 32'd0);

        // Boot and stream until the zero word at 12.
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        push_exp(32'h0050_8413, 32'h0000_0000);
        push_exp(32'h0041_0503, 32'h0000_0004);
        push_exp(32'h0091_2223, 32'h0000_0008);
        tick();
        chk("boot_edge1_valid", {31'd0, bus_if.out_valid}, 32'd0);
        tick();
        chk("edge2_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("edge2_instr", bus_if.out_instr, 32'h0050_8413);
        tick();
        chk("edge3_pc", bus_if.out_pc, 32'h0000_0004);
        tick();
        chk("edge4_pc", bus_if.out_pc, 32'h0000_0008);
        tick();
        chk("edge5_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("edge5_halted", {31'd0, halted}, 32'd1);
        chk("edge5_imem_addr", bus_if.imem_addr, 32'h0000_000C);
        chk("edge5_count", instr_count, 32'd3);
        tick();
        chk("halt_hold_addr", bus_if.imem_addr, 32'h0000_000C);
        chk("halt_hold_halted", {31'd0, halted}, 32'd1);

        // Restart at 0, then stall while holding the word at 4.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_0000;
        tick();
        bus_if.redirect_valid = 1'b0;
        chk("restart_halted", {31'd0, halted}, 32'd0);
        push_exp(32'h0050_8413, 32'h0000_0000);
        tick();
        tick();
        chk("stall_setup_instr", bus_if.out_instr, 32'h0041_0503);
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", bus_if.out_instr, 32'h0041_0503);
            chk("stall_pc", bus_if.out_pc, 32'h0000_0004);
            chk("stall_imem_addr", bus_if.imem_addr, 32'h0000_0008);
            chk("stall_count", instr_count, 32'd4);
        end
        bus_if.out_ready = 1'b1;
        push_exp(32'h0041_0503, 32'h0000_0004);
        push_exp(32'h0091_2223, 32'h0000_0008);
        tick();
        chk("release_instr", bus_if.out_instr, 32'h0091_2223);
        chk("release_count", instr_count, 32'd5);
        tick();
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_count", instr_count, 32'd6);

        // Redirect out of HALT to 16.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_0010;
        tick();
        bus_if.redirect_valid = 1'b0;
        chk("redir16_halted", {31'd0, halted}, 32'd0);
        chk("redir16_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("redir16_misalign", {31'd0, misalign_err}, 32'd0);
        bus_if.out_ready = 1'b0;
        tick();
        chk("redir16_instr", bus_if.out_instr, 32'h0020_8433);
        chk("redir16_pc", bus_if.out_pc, 32'h0000_0010);
        chk("redir16_pc_plus4", bus_if.out_pc_plus4, 32'h0000_0014);
        chk("redir16_valid2", {31'd0, bus_if.out_valid}, 32'd1);

        // Misaligned redirect to 6 while decode is stalling: flush, one-cycle error pulse.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_0006;
        tick();
        bus_if.redirect_valid = 1'b0;
        chk("mis_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_imem_addr", bus_if.imem_addr, 32'h0000_0004);
        chk("mis_count", instr_count, 32'd6);
        tick();
        chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);
        chk("mis_next_instr", bus_if.out_instr, 32'h0041_0503);
        chk("mis_next_valid", {31'd0, bus_if.out_valid}, 32'd1);

        // Redirect coinciding with the zero word at 12: no HALT; handshake still counted.
        bus_if.out_ready = 1'b1;
        push_exp(32'h0041_0503, 32'h0000_0004);
        tick();
        chk("pre_zero_addr", bus_if.imem_addr, 32'h0000_000C);
        push_exp(32'h0091_2223, 32'h0000_0008);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h0000_0010;
        tick();
        bus_if.redirect_valid = 1'b0;
        chk("rz_halted", {31'd0, halted}, 32'd0);
        chk("rz_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rz_imem_addr", bus_if.imem_addr, 32'h0000_0010);
        chk("rz_count", instr_count, 32'd8);
        tick();
        chk("rz_instr", bus_if.out_instr, 32'h0020_8433);
        chk("rz_halted2", {31'd0, halted}, 32'd0);

        // Redirect to the top word: PC and pc_plus4 wrap to zero.
        push_exp(32'h0020_8433, 32'h0000_0010);
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus_if.redirect_valid = 1'b0;
        chk("wrap_addr", bus_if.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_count", instr_count, 32'd9);
        push_exp(32'h0010_0093, 32'hFFFF_FFFC);
        tick();
        chk("wrap_instr", bus_if.out_instr, 32'h0010_0093);
        chk("wrap_pc", bus_if.out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", bus_if.out_pc_plus4, 32'h0000_0000);
        chk("wrap_next_addr", bus_if.imem_addr, 32'h0000_0000);
        tick();
        chk("wrap_after_instr", bus_if.out_instr, 32'h0050_8413);
        chk("wrap_after_count", instr_count, 32'd10);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_imem_addr", bus_if.imem_addr, 32'h0000_0000);
        chk("arst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("arst_instr", bus_if.out_instr, 32'h0000_0000);
        chk("arst_pc", bus_if.out_pc, 32'h0000_0000);
        chk("arst_pc_plus4", bus_if.out_pc_plus4, 32'h0000_0000);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("arst_count", instr_count, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("reboot_edge1_valid", {31'd0, bus_if.out_valid}, 32'd0);
        tick();
        chk("reboot_edge2_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("reboot_edge2_instr", bus_if.out_instr, 32'h0050_8413);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
